map_mem_arbiter: RTL and testbench

Round-robin access controller for the auxiliary read/write port of the tile map memory. That memory holds a MAP_MEM_WIDTH-bit state per tile: 0 empty, 1 permanent block, 2 destroyable block, 3 bomb. The arbiter shares one synchronous-read RAM port between NUM_REQ game-logic requesters, such as player collision lookups, bomb placement and explosion clearing, through a valid/ready handshake. It pipelines accepted requests to the RAM, returns read data tagged to the issuing requester, and supports locked read-modify-write sequences. The video read port feeding the pixel pipeline is a separate RAM port and is outside this block.

---
 rtl/map_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_map_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_mem_arbiter.sv
// map_mem_arbiter: round-robin valid/ready arbiter for the tile map memory
// auxiliary port. Supports locked read-modify-write sequences, flags and
// neutralises out-of-range accesses, and returns tagged read data two
// cycles after acceptance.
module map_mem_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MAP_MEM_WIDTH = 2,
  parameter int NUM_ROW       = 11,
  parameter int NUM_COL       = 19,
  localparam int DEPTH        = NUM_ROW * NUM_COL,
  localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ-1:0]               req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*MAP_MEM_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [MAP_MEM_WIDTH-1:0]         rsp_rdata,
  output logic                             err_oob,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [MAP_MEM_WIDTH-1:0]         mem_wdata,
  input  logic [MAP_MEM_WIDTH-1:0]         mem_rdata
);

  localparam int IDW = $clog2(NUM_REQ);
  // Out-of-range reads look like a permanent block so collision logic sees a wall
  localparam logic [MAP_MEM_WIDTH-1:0] OOB_DATA = MAP_MEM_WIDTH'(1);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t                   r_state;
  logic [IDW-1:0]           r_owner;
  logic [IDW-1:0]           r_last_grant;

  logic                     w_grant_valid;
  logic [IDW-1:0]           w_grant_idx;
  logic [ADDR_WIDTH-1:0]    w_addr_arr  [NUM_REQ];
  logic [MAP_MEM_WIDTH-1:0] w_wdata_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0]    w_sel_addr;
  logic [MAP_MEM_WIDTH-1:0] w_sel_wdata;
  logic                     w_sel_oob;

  logic                     r_s1_valid;
  logic                     r_s1_we;
  logic [IDW-1:0]           r_s1_id;
  logic                     r_s1_oob;
  logic [ADDR_WIDTH-1:0]    r_s1_addr;
  logic [MAP_MEM_WIDTH-1:0] r_s1_wdata;
  logic                     r_s2_valid;
  logic [IDW-1:0]           r_s2_id;
  logic                     r_s2_oob;
  logic                     r_err_oob;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wdata_arr[g] = req_wdata[g*MAP_MEM_WIDTH +: MAP_MEM_WIDTH];
    end
  endgenerate

  // Grant selection: lock owner only while locked, else round-robin after last grant
  always_comb begin
    logic [IDW:0]   v_sum;
    logic [IDW-1:0] v_cand;
    logic           v_hit;
    v_sum         = '0;
    v_cand        = '0;
    v_hit         = 1'b0;
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    if (rst) begin
      w_grant_valid = 1'b0;
    end else if (r_state == ST_LOCKED) begin
      w_grant_valid = req_valid[r_owner];
      w_grant_idx   = r_owner;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        v_sum         = {1'b0, r_last_grant} + (IDW+1)'(k);
        v_cand        = (v_sum >= (IDW+1)'(NUM_REQ)) ? IDW'(v_sum - (IDW+1)'(NUM_REQ))
                                                     : IDW'(v_sum);
        v_hit         = !w_grant_valid && req_valid[v_cand];
        w_grant_idx   = v_hit ? v_cand : w_grant_idx;
        w_grant_valid = w_grant_valid | v_hit;
      end
    end
  end

  // One-hot ready on the granted requester and selection of its request fields
  always_comb begin
    req_ready              = '0;
    req_ready[w_grant_idx] = w_grant_valid;
    w_sel_addr             = w_addr_arr[w_grant_idx];
    w_sel_wdata            = w_wdata_arr[w_grant_idx];
    w_sel_oob              = ({1'b0, w_sel_addr} >= (ADDR_WIDTH+1)'(DEPTH));
  end

  // Arbiter FSM: round-robin pointer and lock ownership, updated on every transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_grant <= IDW'(NUM_REQ - 1);
    end else if (w_grant_valid) begin
      r_last_grant <= w_grant_idx;
      if (req_lock[w_grant_idx]) begin
        r_state <= ST_LOCKED;
        r_owner <= w_grant_idx;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  // Request pipeline: stage 1 drives the RAM, stage 2 tracks outstanding reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_we    <= 1'b0;
      r_s1_id    <= '0;
      r_s1_oob   <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_wdata <= '0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
      r_s2_oob   <= 1'b0;
      r_err_oob  <= 1'b0;
    end else begin
      r_s1_valid <= w_grant_valid;
      r_err_oob  <= w_grant_valid & w_sel_oob;
      if (w_grant_valid) begin
        r_s1_we    <= req_we[w_grant_idx];
        r_s1_id    <= w_grant_idx;
        r_s1_oob   <= w_sel_oob;
        r_s1_addr  <= w_sel_addr;
        r_s1_wdata <= w_sel_wdata;
      end
      r_s2_valid <= r_s1_valid & ~r_s1_we;
      r_s2_id    <= r_s1_id;
      r_s2_oob   <= r_s1_oob;
    end
  end

  // RAM port from stage 1; out-of-range accesses never reach the RAM
  always_comb begin
    mem_en    = r_s1_valid & ~r_s1_oob;
    mem_we    = r_s1_valid & ~r_s1_oob & r_s1_we;
    mem_addr  = r_s1_addr;
    mem_wdata = r_s1_wdata;
    err_oob   = r_err_oob;
  end

  // Read response: strobe the issuing requester, substitute wall data when out of range
  always_comb begin
    rsp_valid          = '0;
    rsp_valid[r_s2_id] = r_s2_valid;
    if (r_s2_valid) begin
      rsp_rdata = r_s2_oob ? OOB_DATA : mem_rdata;
    end else begin
      rsp_rdata = '0;
    end
  end

endmodule

// File: tb/tb_map_mem_arbiter.sv
// Directed bench for map_mem_arbiter with a RAM model and a read-response scoreboard.
module tb_map_mem_arbiter;

  localparam int NR = 4;
  localparam int W  = 2;
  localparam int AW = 8;
  localparam int DEPTH = 209;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid, req_we, req_lock;
  logic [NR*AW-1:0] req_addr;
  logic [NR*W-1:0] req_wdata;
  logic [NR-1:0]   req_ready, rsp_valid;
  logic [W-1:0]    rsp_rdata;
  logic            err_oob, mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [W-1:0]    mem_wdata;
  logic [W-1:0]    mem_rdata;

  typedef struct { int id; logic [W-1:0] data; } exp_t;
  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] sh      [0:255];
  logic [W-1:0] ram     [0:255];
  logic         written [0:255];

  map_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err_oob(err_oob),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] init_val(input int a);
    if (a == 20) return 2'd2;
    return 2'((a * 3 + 1) % 4);
  endfunction

  // Synchronous-read RAM model; unwritten cells hold their preset pattern
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= (written[mem_addr] === 1'b1) ? ram[mem_addr] : init_val(int'(mem_addr));
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Response monitor: every read response must match the oldest scoreboard entry
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_valid), 32'(4'b0001 << e.id));
          chk("rsp_data", 32'(rsp_rdata), 32'(e.data));
        end
      end else begin
        chk("rsp_idle_data", 32'(rsp_rdata), 32'd0);
      end
    end
  end

  task automatic clr();
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_req(input int i, input bit we, input bit lock, input int addr, input int wd);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_lock[i]  = lock;
    req_addr[i*AW +: AW] = AW'(addr);
    req_wdata[i*W +: W]  = W'(wd);
  endtask

  // Record the handshake that happens this cycle, then advance to the next negedge
  task automatic tick();
    #1;
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        int a;
        exp_t e;
        a = int'(req_addr[i*AW +: AW]);
        if (!req_we[i]) begin
          e.id = i;
          e.data = (a >= DEPTH) ? 2'd1 : sh[a];
          sb.push_back(e);
        end else if (a < DEPTH) begin
          sh[a] = req_wdata[i*W +: W];
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rspv"},  32'(rsp_valid), 32'd0);
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_err"},   32'(err_oob),   32'd0);
    chk({tag, "_en"},    32'(mem_en),    32'd0);
    chk({tag, "_we"},    32'(mem_we),    32'd0);
    chk({tag, "_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      sh[a] = init_val(a);
      written[a] = 1'b0;
    end
    rst = 1'b1;
    clr();
    #1;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Round-robin with all four requesters valid
    for (int k = 0; k < 8; k++) begin
      clr();
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, 30 + 4*k + i, 0);
      #1;
      chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
    end

    // Single read by requester 2
    clr();
    set_req(2, 1'b0, 1'b0, 20, 0);
    #1;
    chk("rd_ready", 32'(req_ready), 32'(4'b0100));
    tick();
    chk("rd_en", 32'(mem_en), 32'd1);
    chk("rd_we", 32'(mem_we), 32'd0);
    chk("rd_addr", 32'(mem_addr), 32'd20);
    clr();
    tick();
    chk("rd_rspv", 32'(rsp_valid), 32'(4'b0100));
    chk("rd_rdata", 32'(rsp_rdata), 32'd2);

    // Locked read-modify-write by requester 1 while requester 0 waits
    clr();
    set_req(1, 1'b0, 1'b1, 5, 0);
    #1;
    chk("lk_first", 32'(req_ready), 32'(4'b0010));
    tick();
    clr();
    set_req(0, 1'b0, 1'b0, 5, 0);
    #1;
    chk("lk_block", 32'(req_ready), 32'd0);
    tick();
    clr();
    set_req(0, 1'b0, 1'b0, 5, 0);
    set_req(1, 1'b1, 1'b0, 5, 3);
    #1;
    chk("lk_write", 32'(req_ready), 32'(4'b0010));
    tick();
    clr();
    set_req(0, 1'b0, 1'b0, 5, 0);
    #1;
    chk("lk_release", 32'(req_ready), 32'(4'b0001));
    tick();
    clr();
    tick();
    chk("lk_rspv", 32'(rsp_valid), 32'(4'b0001));
    chk("lk_rdata", 32'(rsp_rdata), 32'd3);

    // Out-of-range read then write by requester 3
    clr();
    set_req(3, 1'b0, 1'b0, 209, 0);
    #1;
    chk("oob_rd_ready", 32'(req_ready), 32'(4'b1000));
    tick();
    chk("oob_t1_en", 32'(mem_en), 32'd0);
    chk("oob_t1_err", 32'(err_oob), 32'd1);
    clr();
    set_req(3, 1'b1, 1'b0, 255, 2);
    #1;
    chk("oob_wr_ready", 32'(req_ready), 32'(4'b1000));
    tick();
    chk("oob_t2_en", 32'(mem_en), 32'd0);
    chk("oob_t2_err", 32'(err_oob), 32'd1);
    chk("oob_rspv", 32'(rsp_valid), 32'(4'b1000));
    chk("oob_rdata", 32'(rsp_rdata), 32'd1);
    clr();
    tick();
    chk("oob_t3_err", 32'(err_oob), 32'd0);
    chk("oob_t3_rspv", 32'(rsp_valid), 32'd0);

    // Write then read of the same address from different requesters
    clr();
    set_req(0, 1'b1, 1'b0, 7, 3);
    #1;
    chk("raw_wr_ready", 32'(req_ready), 32'(4'b0001));
    tick();
    chk("raw_en", 32'(mem_en), 32'd1);
    chk("raw_we", 32'(mem_we), 32'd1);
    chk("raw_addr", 32'(mem_addr), 32'd7);
    chk("raw_wdata", 32'(mem_wdata), 32'd3);
    clr();
    set_req(1, 1'b0, 1'b0, 7, 0);
    #1;
    chk("raw_rd_ready", 32'(req_ready), 32'(4'b0010));
    tick();
    chk("raw_no_rsp", 32'(rsp_valid), 32'd0);
    clr();
    tick();
    chk("raw_rspv", 32'(rsp_valid), 32'(4'b0010));
    chk("raw_rdata", 32'(rsp_rdata), 32'd3);

    // Reset one cycle after a read transfer
    clr();
    set_req(2, 1'b0, 1'b0, 20, 0);
    #1;
    chk("mr_ready", 32'(req_ready), 32'(4'b0100));
    tick();
    chk("mr_en_before", 32'(mem_en), 32'd1);
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, 40 + i, 0);
    #1;
    chk_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'(4'b0001));
    chk("post_rst_rspv", 32'(rsp_valid), 32'd0);
    tick();
    clr();
    tick();
    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
